instr_fetch: RTL and testbench

//  Fetch stage feeding the main decoder/control unit. Holds the PC and issues word reads to instruction memory

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_buffer.sv | 48 ++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode definitions: opcodes, NOP word, reset PC and fetch state encoding.
// Imported by the fetch stage and its instruction buffer.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE     = 6'b000000;
    localparam logic [5:0]  OP_J         = 6'b000010;
    localparam logic [5:0]  OP_LW        = 6'b100011;
    localparam logic [5:0]  OP_SW        = 6'b101011;
    localparam logic [5:0]  OP_BEQ       = 6'b000100;
    localparam logic [5:0]  OP_ADDI      = 6'b001000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_buffer.sv
// Two-entry {pc,instr} queue between imem responses and decode; head visible same cycle it is written+1.
// Caller never pushes into a full queue unless it also pops; flush wins over push and pop.
module if_buffer
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  if_entry_t push_entry,
    input  logic      pop,
    input  logic      flush,
    output logic [1:0] count,
    output logic      head_valid,
    output if_entry_t head_entry
);

    if_entry_t entries [2];
    logic      wr_ptr;
    logic      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // When full, push+pop writes the slot being vacated by the head.
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_entry = entries[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, 2-entry instruction queue, redirect flush; rsp -> if_valid in 1 cycle.
// Decode stall only holds the queue; fetch parks in S_IDLE when the queue would be full.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [5:0]  op_c,
    output logic [5:0]  fnc,
    output logic        misalign_err
);

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    fetch_state_e state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic         discard, discard_nxt;
    logic [1:0]   count;
    logic         head_valid;
    if_entry_t    head_entry;
    if_entry_t    push_entry;
    logic         push;
    logic         pop;
    logic [2:0]   level;

    // A redirect invalidates the displayed head, so it is never consumed that cycle.
    assign pop        = head_valid && !stall && !redirect_valid;
    assign push_entry = {fetch_pc - 32'd4, imem_rsp_data};

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        discard_nxt  = discard;
        push         = 1'b0;
        level        = {1'b0, count} - {2'b0, pop};
        case (state)
            S_IDLE: begin
                if (level < DEPTH) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_nxt    = S_RSP;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                end
            end
            S_RSP: begin
                if (imem_rsp_valid) begin
                    push        = !discard && !redirect_valid;
                    discard_nxt = 1'b0;
                    level       = level + {2'b0, push};
                    state_nxt   = (level < DEPTH) ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // An accepted-but-unanswered request must have its response swallowed.
        if (redirect_valid) begin
            fetch_pc_nxt = word_align(redirect_pc);
            if ((state == S_RSP && !imem_rsp_valid) || (state == S_REQ && imem_req_ready)) begin
                discard_nxt = 1'b1;
            end
            if (state == S_IDLE) begin
                state_nxt = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            discard      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            discard  <= discard_nxt;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

    if_buffer u_if_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (head_valid),
        .head_entry (head_entry)
    );

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = fetch_pc;
    assign if_valid       = head_valid;
    assign if_instr       = head_valid ? head_entry.instr : INSTR_NOP;
    assign if_pc          = head_valid ? head_entry.pc : 32'h0000_0000;
    assign if_pc4         = if_pc + 32'd4;
    assign op_c           = if_instr[31:26];
    assign fnc            = if_instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, hand-written corner sequences, then randomized traffic
// checked against a program-order model of the fetch stream.
module tb_instr_fetch;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int NV = 22;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [5:0]  op_c;
    logic [5:0]  fnc;
    logic        misalign_err;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .op_c           (op_c),
        .fnc            (fnc),
        .misalign_err   (misalign_err)
    );

    typedef struct {
        bit          rdy;
        bit          rsp;
        logic [31:0] dat;
        bit          st;
        bit          rv;
        logic [31:0] rpc;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_ifv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        bit          e_mis;
    } vec_t;

    vec_t tbl [NV];

    int n_checks = 0;
    int n_fail   = 0;

    // Program-order model state
    logic [31:0] exp_next, exp_fetch, pend_addr;
    bit          exp_mis, just_red, pend;
    int          pend_lat, acc_total, deliv;
    bit          obs_ifv, obs_rv, obs_mis;
    logic [31:0] obs_pc, obs_addr;

    function automatic vec_t mk(bit rdy, bit rsp, logic [31:0] dat, bit st, bit rv, logic [31:0] rpc,
                                bit e_rv, logic [31:0] e_addr, bit e_ifv, logic [31:0] e_pc,
                                logic [31:0] e_instr, bit e_mis);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.dat = dat; v.st = st; v.rv = rv; v.rpc = rpc;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2C5A_1F03;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, " req_addr"}, imem_req_addr, RST_PC);
        chk({tag, " if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, " if_instr"}, if_instr, INSTR_NOP);
        chk({tag, " if_pc"}, if_pc, 32'h0);
        chk({tag, " if_pc4"}, if_pc4, 32'h4);
        chk({tag, " misalign"}, 32'(misalign_err), 32'd0);
    endtask

    task automatic model_init();
        exp_next  = RST_PC;
        exp_fetch = RST_PC;
        exp_mis   = 1'b0;
        just_red  = 1'b0;
        pend      = 1'b0;
        pend_lat  = 0;
        acc_total = 0;
        deliv     = 0;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
    endtask

    // Leaves time at posedge+1 with rst_n just released and the DUT in S_IDLE.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        check_reset_outputs(tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_init();
    endtask

    task automatic run_cycle(input bit rnd, input bit st_i, input bit rdy_i, input bit rv_i,
                             input logic [31:0] rpc_i);
        bit          st, rdy, rv, acc;
        logic [31:0] tgt, w;
        int          r;
        if (rnd) begin
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            r   = int'($urandom_range(0, 15));
            if (r == 0) begin
                tgt = 32'hFFFF_FFF8;
            end else begin
                tgt = $urandom_range(0, 1023) << 2;
                if (r == 1) tgt[0] = 1'b1;
            end
        end else begin
            st = st_i; rdy = rdy_i; rv = rv_i; tgt = rpc_i;
        end
        stall          = st;
        imem_req_ready = rdy;
        redirect_valid = rv;
        redirect_pc    = tgt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend) begin
            if (pend_lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_lat--;
            end
        end
        @(negedge clk);
        obs_ifv  = if_valid;
        obs_pc   = if_pc;
        obs_rv   = imem_req_valid;
        obs_addr = imem_req_addr;
        obs_mis  = misalign_err;
        if (!if_valid) chk("nop while empty", if_instr, INSTR_NOP);
        if (just_red) chk("empty after redirect", 32'(if_valid), 32'd0);
        if (if_valid) begin
            w = mem_word(exp_next);
            chk("if_pc order", if_pc, exp_next);
            chk("if_instr", if_instr, w);
            chk("if_pc4", if_pc4, exp_next + 32'd4);
            chk("op_c", 32'(op_c), 32'(w[31:26]));
            chk("fnc", 32'(fnc), 32'(w[5:0]));
            if (!st && !rv) deliv++;
        end
        if (imem_req_valid) begin
            chk("req_addr order", imem_req_addr, exp_fetch);
            chk("single outstanding", 32'(pend), 32'd0);
        end
        chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
        acc = imem_req_valid && rdy;
        if (rv) begin
            exp_next  = {tgt[31:2], 2'b00};
            exp_fetch = exp_next;
            exp_mis   = exp_mis | (tgt[1:0] != 2'b00);
            just_red  = 1'b1;
        end else begin
            just_red = 1'b0;
            if (if_valid && !st) exp_next = exp_next + 32'd4;
            if (acc) exp_fetch = exp_fetch + 32'd4;
        end
        if (acc) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_lat  = rnd ? int'($urandom_range(0, 3)) : 0;
            acc_total++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;

        //             rdy rsp dat           st rv rpc        e_rv e_addr       ifv e_pc         e_instr       mis
        tbl[0]  = mk(1, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        0);
        tbl[1]  = mk(1, 0, 32'h0,         0, 0, 32'h0,     1, 32'h0,     0, 32'h0,     32'h0,        0);
        tbl[2]  = mk(1, 1, 32'h8C08_0004, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        0);
        tbl[3]  = mk(1, 0, 32'h0,         0, 0, 32'h0,     1, 32'h4,     1, 32'h0,     32'h8C08_0004, 0);
        tbl[4]  = mk(1, 1, 32'h2009_0005, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        0);
        tbl[5]  = mk(0, 0, 32'h0,         0, 0, 32'h0,     1, 32'h8,     1, 32'h4,     32'h2009_0005, 0);
        tbl[6]  = mk(1, 0, 32'h0,         0, 0, 32'h0,     1, 32'h8,     0, 32'h0,     32'h0,        0);
        tbl[7]  = mk(0, 0, 32'h0,         0, 1, 32'h42,    0, 32'h0,     0, 32'h0,     32'h0,        0);
        tbl[8]  = mk(0, 0, 32'h0,         0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        1);
        tbl[9]  = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        1);
        tbl[10] = mk(1, 0, 32'h0,         0, 0, 32'h0,     1, 32'h40,    0, 32'h0,     32'h0,        1);
        tbl[11] = mk(0, 1, 32'h1000_FFFF, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        1);
        tbl[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,     1, 32'h44,    1, 32'h40,    32'h1000_FFFF, 1);
        tbl[13] = mk(1, 0, 32'h0,         0, 1, 32'h100,   1, 32'h44,    0, 32'h0,     32'h0,        1);
        tbl[14] = mk(0, 1, 32'hAAAA_5555, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        1);
        tbl[15] = mk(1, 0, 32'h0,         0, 0, 32'h0,     1, 32'h100,   0, 32'h0,     32'h0,        1);
        tbl[16] = mk(0, 1, 32'h8C0A_0008, 0, 1, 32'h200,   0, 32'h0,     0, 32'h0,     32'h0,        1);
        tbl[17] = mk(1, 0, 32'h0,         0, 0, 32'h0,     1, 32'h200,   0, 32'h0,     32'h0,        1);
        tbl[18] = mk(0, 1, 32'hAC0B_000C, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,     32'h0,        1);
        tbl[19] = mk(0, 0, 32'h0,         1, 0, 32'h0,     1, 32'h204,   1, 32'h200,   32'hAC0B_000C, 1);
        tbl[20] = mk(0, 0, 32'h0,         1, 1, 32'h300,   1, 32'h204,   1, 32'h200,   32'hAC0B_000C, 1);
        tbl[21] = mk(0, 0, 32'h0,         0, 0, 32'h0,     1, 32'h300,   0, 32'h0,     32'h0,        1);

        clear_inputs();
        do_reset("reset");

        for (int i = 0; i < NV; i++) begin
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rsp;
            imem_rsp_data  = tbl[i].dat;
            stall          = tbl[i].st;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(tbl[i].e_ifv));
            chk($sformatf("vec%0d if_instr", i), if_instr, tbl[i].e_instr);
            chk($sformatf("vec%0d misalign", i), 32'(misalign_err), 32'(tbl[i].e_mis));
            if (tbl[i].e_ifv) begin
                chk($sformatf("vec%0d if_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d if_pc4", i), if_pc4, tbl[i].e_pc + 32'd4);
                chk($sformatf("vec%0d op_c", i), 32'(op_c), 32'(tbl[i].e_instr[31:26]));
                chk($sformatf("vec%0d fnc", i), 32'(fnc), 32'(tbl[i].e_instr[5:0]));
            end
            @(posedge clk); #1;
        end

        // Stall fills the queue with exactly two words, then drains in order.
        do_reset("reset2");
        for (int k = 0; k < 10; k++) run_cycle(0, 1, 1, 0, 32'h0);
        chk("stall requests accepted", 32'(acc_total), 32'd2);
        chk("stall fetch idle", 32'(obs_rv), 32'd0);
        chk("stall head pc", obs_pc, RST_PC);
        run_cycle(0, 0, 1, 0, 32'h0);
        chk("drain first valid", 32'(obs_ifv), 32'd1);
        chk("drain first pc", obs_pc, RST_PC);
        run_cycle(0, 0, 1, 0, 32'h0);
        chk("drain second valid", 32'(obs_ifv), 32'd1);
        chk("drain second pc", obs_pc, RST_PC + 32'd4);

        // Misaligned redirect: aligned fetch address, sticky error.
        run_cycle(0, 0, 1, 1, 32'h42);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            run_cycle(0, 0, 1, 0, 32'h0);
            if (obs_rv && !seen) begin
                chk("misaligned redirect req_addr", obs_addr, 32'h40);
                seen = 1'b1;
            end
        end
        chk("misaligned redirect issued", 32'(seen), 32'd1);
        chk("misalign sticky", 32'(obs_mis), 32'd1);

        // Reset while a request is outstanding; the stale response after release is ignored.
        for (int k = 0; k < 10 && !pend; k++) run_cycle(0, 0, 1, 0, 32'h0);
        chk("request in flight before reset", 32'(pend), 32'd1);
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_reset_outputs("async reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("post-reset idle req", 32'(imem_req_valid), 32'd0);
        chk("post-reset idle if_valid", 32'(if_valid), 32'd0);
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post-reset req_valid", 32'(imem_req_valid), 32'd1);
            chk("post-reset req_addr", imem_req_addr, RST_PC);
            chk("stale rsp not queued", 32'(if_valid), 32'd0);
            @(posedge clk); #1;
        end
        model_init();
        for (int k = 0; k < 4; k++) run_cycle(0, 0, 1, 0, 32'h0);
        chk("post-reset first fetch delivered", 32'(deliv >= 1), 32'd1);

        // Randomized traffic, redirects (incl. wrap near 2^32 and misaligned targets).
        do_reset("reset3");
        for (int k = 0; k < 3000; k++) run_cycle(1, 0, 0, 0, 32'h0);
        chk("random forward progress", 32'(deliv > 150), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
